// File: rtl/arm_ctrl_stage.sv
// arm_ctrl_stage: registered ID-stage control decoder with ARM condition squash and
// a STAGES-deep stall/flush pipeline. Optional CTRL_SQUASH_CNT_EN adds squash/illegal counters.
module arm_ctrl_stage #(
    parameter int ALU_CMD_W = 4,
    parameter int STAGES    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [1:0]           mode,
    input  logic [3:0]           op_code,
    input  logic                 s,
    input  logic [3:0]           cond,
    input  logic [3:0]           nzcv,
    input  logic                 stall,
    input  logic                 flush,
    output logic                 out_valid,
    output logic                 wb_en,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [ALU_CMD_W-1:0] alu_cmd,
    output logic                 branch,
    output logic                 status_en,
    output logic                 illegal
`ifdef CTRL_SQUASH_CNT_EN
    ,
    output logic [15:0]          squash_cnt,
    output logic [15:0]          illegal_cnt
`endif
);

    typedef struct packed {
        logic                 valid;
        logic                 wb_en;
        logic                 mem_read;
        logic                 mem_write;
        logic [ALU_CMD_W-1:0] alu_cmd;
        logic                 branch;
        logic                 status_en;
        logic                 illegal;
    } ctl_t;

    if (STAGES < 1 || STAGES > 3) begin : g_bad_stages
        $error("arm_ctrl_stage: STAGES must be 1..3");
    end

    ctl_t              dec;
    ctl_t              stage_in;
    logic [3:0]        cmd4;
    logic              cond_pass;
    logic              n_f, z_f, c_f, v_f;
    ctl_t [STAGES-1:0] pipe_q, pipe_d;

    assign {n_f, z_f, c_f, v_f} = nzcv;

    always_comb begin
        dec  = '0;
        cmd4 = 4'b0000;
        unique case (mode)
            2'b00: begin
                dec.wb_en     = 1'b1;
                dec.status_en = s;
                case (op_code)
                    4'b1101: cmd4 = 4'b0001;
                    4'b1111: cmd4 = 4'b1001;
                    4'b0100: cmd4 = 4'b0010;
                    4'b0101: cmd4 = 4'b0011;
                    4'b0010: cmd4 = 4'b0100;
                    4'b0110: cmd4 = 4'b0101;
                    4'b0000: cmd4 = 4'b0110;
                    4'b1100: cmd4 = 4'b0111;
                    4'b0001: cmd4 = 4'b1000;
                    4'b1010: begin cmd4 = 4'b0100; dec.wb_en = 1'b0; end
                    4'b1000: begin cmd4 = 4'b0110; dec.wb_en = 1'b0; end
                    default: begin
                        dec.wb_en     = 1'b0;
                        dec.status_en = 1'b0;
                        dec.illegal   = 1'b1;
                    end
                endcase
            end
            2'b01: begin
                if (op_code == 4'b0100) begin
                    cmd4          = 4'b0010;
                    dec.mem_read  = s;
                    dec.mem_write = ~s;
                    dec.wb_en     = s;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            2'b10:   dec.branch  = 1'b1;
            default: dec.illegal = 1'b1;
        endcase
        dec.alu_cmd = ALU_CMD_W'(cmd4);
    end

    always_comb begin
        cond_pass = 1'b0;
        case (cond)
            4'b0000: cond_pass = z_f;
            4'b0001: cond_pass = ~z_f;
            4'b0010: cond_pass = c_f;
            4'b0011: cond_pass = ~c_f;
            4'b0100: cond_pass = n_f;
            4'b0101: cond_pass = ~n_f;
            4'b0110: cond_pass = v_f;
            4'b0111: cond_pass = ~v_f;
            4'b1000: cond_pass = c_f & ~z_f;
            4'b1001: cond_pass = ~c_f | z_f;
            4'b1010: cond_pass = (n_f == v_f);
            4'b1011: cond_pass = (n_f != v_f);
            4'b1100: cond_pass = ~z_f & (n_f == v_f);
            4'b1101: cond_pass = z_f | (n_f != v_f);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    // A failed condition keeps alu_cmd/illegal visible but kills every side effect.
    always_comb begin
        stage_in = '0;
        if (in_valid) begin
            stage_in       = dec;
            stage_in.valid = 1'b1;
            if (!cond_pass) begin
                stage_in.wb_en     = 1'b0;
                stage_in.mem_read  = 1'b0;
                stage_in.mem_write = 1'b0;
                stage_in.branch    = 1'b0;
                stage_in.status_en = 1'b0;
            end
        end
    end

    always_comb begin
        pipe_d = pipe_q;
        if (flush) begin
            pipe_d = '0;
        end else if (!stall) begin
            pipe_d[0] = stage_in;
            for (int k = 1; k < STAGES; k++) pipe_d[k] = pipe_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pipe_q <= '0;
        else        pipe_q <= pipe_d;
    end

    assign out_valid = pipe_q[STAGES-1].valid;
    assign wb_en     = pipe_q[STAGES-1].wb_en;
    assign mem_read  = pipe_q[STAGES-1].mem_read;
    assign mem_write = pipe_q[STAGES-1].mem_write;
    assign alu_cmd   = pipe_q[STAGES-1].alu_cmd;
    assign branch    = pipe_q[STAGES-1].branch;
    assign status_en = pipe_q[STAGES-1].status_en;
    assign illegal   = pipe_q[STAGES-1].illegal;

`ifdef CTRL_SQUASH_CNT_EN
    logic        accept;
    logic [15:0] squash_cnt_q, squash_cnt_d;
    logic [15:0] illegal_cnt_q, illegal_cnt_d;

    assign accept = in_valid & ~stall & ~flush;

    always_comb begin
        squash_cnt_d  = squash_cnt_q;
        illegal_cnt_d = illegal_cnt_q;
        if (accept && !cond_pass && squash_cnt_q != 16'hFFFF)
            squash_cnt_d = squash_cnt_q + 16'd1;
        if (accept && dec.illegal && illegal_cnt_q != 16'hFFFF)
            illegal_cnt_d = illegal_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            squash_cnt_q  <= 16'h0000;
            illegal_cnt_q <= 16'h0000;
        end else begin
            squash_cnt_q  <= squash_cnt_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    assign squash_cnt  = squash_cnt_q;
    assign illegal_cnt = illegal_cnt_q;
`endif

endmodule

// File: tb/tb_arm_ctrl_stage.sv
// Bench for arm_ctrl_stage: three DUTs (STAGES=1,2,3) on shared stimulus, table vectors,
// randomized traffic against a flag-rule reference model, and reset/stall/flush sequences.
module tb_arm_ctrl_stage;

    typedef struct packed {
        logic       v, wb, mr, mw;
        logic [3:0] alu;
        logic       br, se, il;
    } ctl_t;

    typedef struct {
        logic [1:0] mode;
        logic [3:0] op;
        logic       s;
        logic [3:0] cond;
        logic [3:0] nzcv;
        ctl_t       exp;
    } vec_t;

    logic clk = 1'b0, rst_n = 1'b0;
    logic in_valid = 1'b0, s = 1'b0, stall = 1'b0, flush = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [3:0] op_code = 4'h0, cond = 4'h0, nzcv = 4'h0;

    logic [2:0] o_v, o_wb, o_mr, o_mw, o_br, o_se, o_il;
    logic [3:0] o_alu [3];
`ifdef CTRL_SQUASH_CNT_EN
    logic [15:0] o_sq [3];
    logic [15:0] o_ic [3];
    int sq_m = 0, ic_m = 0;
`endif

    int   checks = 0, errors = 0;
    ctl_t mp [3][3];
    vec_t vt [18];
    // Data-processing opcode -> ALU command; -1 marks opcodes with no decode.
    int   dp_alu [16] = '{6, 8, 4, -1, 2, 3, 5, -1, 6, -1, 4, -1, 7, 1, -1, 9};
    logic [3:0] legal_ops [12] = '{4'hD, 4'hF, 4'h4, 4'h5, 4'h2, 4'h6, 4'h0, 4'hC, 4'h1, 4'hA, 4'h8, 4'h4};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        arm_ctrl_stage #(.ALU_CMD_W(4), .STAGES(g + 1)) u_dut (
            .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mode(mode), .op_code(op_code),
            .s(s), .cond(cond), .nzcv(nzcv), .stall(stall), .flush(flush),
            .out_valid(o_v[g]), .wb_en(o_wb[g]), .mem_read(o_mr[g]), .mem_write(o_mw[g]),
            .alu_cmd(o_alu[g]), .branch(o_br[g]), .status_en(o_se[g]), .illegal(o_il[g])
`ifdef CTRL_SQUASH_CNT_EN
            , .squash_cnt(o_sq[g]), .illegal_cnt(o_ic[g])
`endif
        );
    end

    function automatic ctl_t mk(logic v, wb, mr, mw, logic [3:0] alu, logic br, se, il);
        ctl_t c;
        c = '{v: v, wb: wb, mr: mr, mw: mw, alu: alu, br: br, se: se, il: il};
        return c;
    endfunction

    // ARM rule: cond[3:1] selects a flag test, cond[0] inverts it (1111 is the inverted AL).
    function automatic logic ref_pass(logic [3:0] c, logic [3:0] f);
        logic n, z, cy, v, base;
        {n, z, cy, v} = f;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    function automatic ctl_t ref_dec(logic iv, logic [1:0] md, logic [3:0] op, logic sb,
                                     logic [3:0] c, logic [3:0] f);
        ctl_t r = '0;
        if (!iv) return r;
        r.v = 1'b1;
        if (md == 2'd0 && dp_alu[op] >= 0) begin
            r.alu = 4'(dp_alu[op]);
            r.wb  = !(op == 4'h8 || op == 4'hA);
            r.se  = sb;
        end else if (md == 2'd1 && op == 4'h4) begin
            r.alu = 4'h2;
            r.mr  = sb;
            r.wb  = sb;
            r.mw  = !sb;
        end else if (md == 2'd2) begin
            r.br = 1'b1;
        end else begin
            r.il = 1'b1;
        end
        if (!ref_pass(c, f)) begin
            r.wb = 0; r.mr = 0; r.mw = 0; r.br = 0; r.se = 0;
        end
        return r;
    endfunction

    function automatic ctl_t dut_out(int g);
        return mk(o_v[g], o_wb[g], o_mr[g], o_mw[g], o_alu[g], o_br[g], o_se[g], o_il[g]);
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        foreach (mp[a, b]) mp[a][b] = '0;
`ifdef CTRL_SQUASH_CNT_EN
        sq_m = 0;
        ic_m = 0;
`endif
    endtask

    task automatic set_in(logic iv, logic [1:0] md, logic [3:0] op, logic sb,
                          logic [3:0] c, logic [3:0] f);
        in_valid = iv; mode = md; op_code = op; s = sb; cond = c; nzcv = f;
    endtask

    // Advance one clock: update the reference pipelines, then compare every DUT.
    task automatic tick();
        ctl_t nx;
        nx = ref_dec(in_valid, mode, op_code, s, cond, nzcv);
        for (int g = 0; g < 3; g++) begin
            if (flush) begin
                for (int k = 0; k < 3; k++) mp[g][k] = '0;
            end else if (!stall) begin
                for (int k = g; k > 0; k--) mp[g][k] = mp[g][k-1];
                mp[g][0] = nx;
            end
        end
`ifdef CTRL_SQUASH_CNT_EN
        if (in_valid && !stall && !flush) begin
            if (!ref_pass(cond, nzcv) && sq_m < 65535) sq_m++;
            if (nx.il && ic_m < 65535) ic_m++;
        end
`endif
        @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("model_s%0d", g + 1), dut_out(g), mp[g][g]);
`ifdef CTRL_SQUASH_CNT_EN
            chk($sformatf("squash_cnt_s%0d", g + 1), o_sq[g], sq_m);
            chk($sformatf("illegal_cnt_s%0d", g + 1), o_ic[g], ic_m);
`endif
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_model();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        //        mode  op    s  cond  nzcv   expected {v,wb,mr,mw,alu,br,se,il}
        vt[0]  = '{2'd0, 4'h4, 1, 4'hE, 4'h0, mk(1,1,0,0,4'h2,0,1,0)};  // ADD S
        vt[1]  = '{2'd0, 4'hD, 0, 4'hE, 4'h0, mk(1,1,0,0,4'h1,0,0,0)};  // MOV
        vt[2]  = '{2'd0, 4'hF, 1, 4'hE, 4'h0, mk(1,1,0,0,4'h9,0,1,0)};  // MVN S
        vt[3]  = '{2'd0, 4'h2, 0, 4'hE, 4'h0, mk(1,1,0,0,4'h4,0,0,0)};  // SUB
        vt[4]  = '{2'd0, 4'hA, 1, 4'hE, 4'h0, mk(1,0,0,0,4'h4,0,1,0)};  // CMP
        vt[5]  = '{2'd0, 4'h8, 1, 4'hE, 4'h0, mk(1,0,0,0,4'h6,0,1,0)};  // TST
        vt[6]  = '{2'd0, 4'h1, 0, 4'hE, 4'h0, mk(1,1,0,0,4'h8,0,0,0)};  // EOR
        vt[7]  = '{2'd1, 4'h4, 1, 4'h0, 4'h0, mk(1,0,0,0,4'h2,0,0,0)};  // LDR EQ, Z=0
        vt[8]  = '{2'd1, 4'h4, 1, 4'h0, 4'h4, mk(1,1,1,0,4'h2,0,0,0)};  // LDR EQ, Z=1
        vt[9]  = '{2'd1, 4'h4, 0, 4'hE, 4'h0, mk(1,0,0,1,4'h2,0,0,0)};  // STR
        vt[10] = '{2'd1, 4'h5, 1, 4'hE, 4'h0, mk(1,0,0,0,4'h0,0,0,1)};  // mode 01 bad op
        vt[11] = '{2'd3, 4'h4, 1, 4'hE, 4'h0, mk(1,0,0,0,4'h0,0,0,1)};  // mode 11
        vt[12] = '{2'd2, 4'h7, 1, 4'hE, 4'h0, mk(1,0,0,0,4'h0,1,0,0)};  // B AL
        vt[13] = '{2'd2, 4'h7, 0, 4'hF, 4'hF, mk(1,0,0,0,4'h0,0,0,0)};  // B NV
        vt[14] = '{2'd0, 4'h4, 1, 4'hA, 4'h8, mk(1,0,0,0,4'h2,0,0,0)};  // ADD GE, N!=V
        vt[15] = '{2'd0, 4'h4, 1, 4'hC, 4'h0, mk(1,1,0,0,4'h2,0,1,0)};  // ADD GT pass
        vt[16] = '{2'd0, 4'h3, 1, 4'hE, 4'h0, mk(1,0,0,0,4'h0,0,0,1)};  // undefined dp op
        vt[17] = '{2'd3, 4'h0, 0, 4'hF, 4'h0, mk(1,0,0,0,4'h0,0,0,1)};  // illegal + fail

        #1;
        for (int g = 0; g < 3; g++) chk($sformatf("reset_s%0d", g + 1), dut_out(g), 32'h0);
        clear_model();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            set_in(1, vt[i].mode, vt[i].op, vt[i].s, vt[i].cond, vt[i].nzcv);
            tick();
            chk($sformatf("vec%0d", i), dut_out(0), vt[i].exp);
        end

        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 9) < 8, 2'($urandom_range(0, 3)),
                   ($urandom_range(0, 1) == 1) ? legal_ops[$urandom_range(0, 11)] : 4'($urandom),
                   1'($urandom), 4'($urandom), 4'($urandom));
            stall = ($urandom_range(0, 99) < 15);
            flush = ($urandom_range(0, 99) < 5);
            tick();
        end
        stall = 0;
        flush = 0;

        // Async reset mid-stream, then first instruction reaches the STAGES=2 output after 2 edges.
        set_in(1, 2'd0, 4'h4, 1, 4'hE, 4'h0);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        clear_model();
        #1;
        chk("async_rst_s2", dut_out(1), 32'h0);
        chk("async_rst_s3", dut_out(2), 32'h0);
        @(posedge clk);
        #1;
        chk("rst_hold_s2", dut_out(1), 32'h0);
        rst_n = 1'b1;
        tick();
        chk("rst_lat1_s2", o_v[1], 1'b0);
        set_in(0, 2'd0, 4'h0, 0, 4'hE, 4'h0);
        tick();
        chk("rst_lat2_s2", dut_out(1), mk(1,1,0,0,4'h2,0,1,0));

        // Stall freezes STAGES=3 on the oldest of three issued instructions; flush wins over stall.
        set_in(1, 2'd0, 4'h4, 1, 4'hE, 4'h0); tick();
        set_in(1, 2'd0, 4'hD, 0, 4'hE, 4'h0); tick();
        set_in(1, 2'd1, 4'h4, 0, 4'hE, 4'h0); tick();
        chk("issue3_s3", dut_out(2), mk(1,1,0,0,4'h2,0,1,0));
        stall = 1;
        set_in(1, 2'd2, 4'h0, 0, 4'hE, 4'h0);
        tick();
        chk("stall1_s3", dut_out(2), mk(1,1,0,0,4'h2,0,1,0));
        tick();
        chk("stall2_s3", dut_out(2), mk(1,1,0,0,4'h2,0,1,0));
        flush = 1;
        tick();
        stall = 0;
        flush = 0;
        chk("flush0_s3", o_v[2], 1'b0);
        set_in(1, 2'd0, 4'h4, 1, 4'hE, 4'h0);
        for (int i = 1; i <= 2; i++) begin
            tick();
            chk($sformatf("flush%0d_s3", i), o_v[2], 1'b0);
        end
        tick();
        chk("refill_s3", o_v[2], 1'b1);

`ifdef CTRL_SQUASH_CNT_EN
        do_reset();
        set_in(1, 2'd0, 4'h4, 1, 4'hF, 4'h0);
        for (int i = 0; i < 5; i++) begin
            stall = (i == 1 || i == 3);
            tick();
        end
        stall = 0;
        set_in(0, 2'd0, 4'h0, 0, 4'hE, 4'h0);
        tick();
        chk("squash_cnt_3", o_sq[0], 16'd3);
        set_in(1, 2'd3, 4'h0, 0, 4'hF, 4'h0);
        for (int i = 0; i < 65540; i++) tick();
        chk("squash_sat", o_sq[2], 16'hFFFF);
        chk("illegal_sat", o_ic[2], 16'hFFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/arm_ctrl_stage.md
Name: arm_ctrl_stage

Overview:
Parametrised, registered successor of the ID-stage control decoder. Decodes {mode, op_code, s} into the EX control bundle and evaluates the ARM condition field against NZCV. Squashes failed-condition instructions and carries the bundle through STAGES pipeline registers with stall/flush. Sits between instruction decode and the ID/EX boundary.

Parameters:
ALU_CMD_W, 4, alu_cmd width; >=4; 4-bit command codes zero-extended.
STAGES, 1, number of output register stages, legal 1..3; latency in cycles.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous reset, active-low
in_valid  in  1  decode fields valid this cycle
mode  in  2  instruction mode field
op_code  in  4  opcode field
s  in  1  S bit (L bit for memory)
cond  in  4  ARM condition field
nzcv  in  4  current status flags {N,Z,C,V}
stall  in  1  hold all stages
flush  in  1  clear all stages to bubble
out_valid  out  1  bundle valid
wb_en  out  1  register writeback
mem_read  out  1  load
mem_write  out  1  store
alu_cmd  out  ALU_CMD_W  ALU command
branch  out  1  branch taken
status_en  out  1  update status register
illegal  out  1  undecodable instruction

Behaviour:
- Reset (rst_n low, async): every stage cleared; all outputs 0.
- Decode, mode 00 (wb_en=1 unless noted, status_en=s):
  - MOV 1101->0001; MVN 1111->1001; ADD 0100->0010; ADC 0101->0011; SUB 0010->0100.
  - SBC 0110->0101; AND 0000->0110; ORR 1100->0111; EOR 0001->1000.
  - CMP 1010->0100, wb_en=0; TST 1000->0110, wb_en=0.
- Mode 01, op 0100: alu_cmd=0010, status_en=0.
  - s=1 (LDR): mem_read=1, wb_en=1.
  - s=0 (STR): mem_write=1, wb_en=0.
- Mode 10: branch=1, alu_cmd=0, wb_en=0, status_en=0.
- Any other mode/op: all controls 0, illegal=1.
- Condition, standard ARM on nzcv:
  - EQ 0000, NE 0001, CS 0010, CC 0011, MI 0100, PL 0101, VS 0110, VC 0111.
  - HI 1000, LS 1001, GE 1010, LT 1011, GT 1100, LE 1101, AL 1110; 1111 = never.
  - Fail: wb_en, mem_read, mem_write, branch, status_en forced 0; alu_cmd and illegal kept; out_valid still 1.
- in_valid=0: stage-0 input is a bubble (valid 0, all controls 0).
- Pipeline: decode and cond evaluation combinational into stage 0; stage k feeds stage k+1; outputs taken from last stage. Latency = STAGES cycles.
- Priority: flush > stall > advance.
  - flush: all stages become bubbles next edge; the instruction presented that cycle is dropped.
  - stall without flush: every stage holds; inputs ignored.
- nzcv is sampled at the decode cycle. The forwarding of flags from in-flight instructions is the caller's responsibility.
- No X on outputs after reset; a bubble always shows all-zero controls.

Optional Feature:
Macro CTRL_SQUASH_CNT_EN.
- Defined: adds output squash_cnt [15:0] (counts instructions entering stage 0 with in_valid=1, no stall/flush, and condition false) and illegal_cnt [15:0] (same gating, illegal=1).
  - Both saturate at 16'hFFFF; reset to 0 by rst_n.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Reset: rst_n=0 mid-stream with STAGES=2 -> all outputs 0 immediately (async), remain 0 until first valid input propagates 2 cycles after release.
- ADD: mode=00, op=0100, s=1, cond=1110, STAGES=1 -> next cycle out_valid=1, alu_cmd=0010, wb_en=1, status_en=1, others 0.
- Condition: LDR (mode=01, op=0100, s=1), cond=0000, nzcv=0000 -> out_valid=1, mem_read=0, wb_en=0, alu_cmd=0010. Repeat with nzcv=0100 -> mem_read=1, wb_en=1.
- Stall/flush: STAGES=3, issue 3 instructions, stall 2 cycles -> outputs frozen. Assert stall and flush together -> next cycle out_valid=0 for 3 consecutive cycles.
- Illegal and branch: mode=11 -> illegal=1, controls 0. mode=10, cond=1111 -> branch=0, out_valid=1.
- CTRL_SQUASH_CNT_EN: 5 failed-condition instructions, 2 under stall -> squash_cnt=3. Preload near saturation -> holds at 16'hFFFF.
